rsa_result_collector: RTL and testbench
=======================================

Name: rsa_result_collector

Overview:
- Downstream consumer of the RSA core. Captures each 32-bit `result` word the core announces with `o_en` into a 64-entry buffer.
- Keeps a running count and an XOR checksum of the captured words.
- After all 64 words are captured, streams them to the host or readout side over a valid/ready interface and then flags completion.
- Replaces file-dump observation with a synthesizable capture path.

Parameters:
DATA_W, 32, width of one RSA result word
DEPTH, 64, number of words per RSA job
CNT_W, 7, width of the word counter, log2(DEPTH)+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse: clear the buffer and arm capture for a new job
o_en  input  1  RSA core output-enable; each rising edge announces one valid word
result  input  DATA_W  RSA core output word, valid in the first cycle o_en is high
out_valid  output  1  buffered word available on out_data
out_ready  input  1  downstream accepts the word when out_valid && out_ready
out_data  output  DATA_W  buffered word, captured order preserved
out_last  output  1  high with the final (DEPTH-1) word during drain
count  output  CNT_W  number of words captured in the current job
checksum  output  DATA_W  XOR of all words captured in the current job
done  output  1  job captured and fully drained; held until next start
overflow  output  1  sticky: an o_en edge arrived while not in COLLECT after start

Behaviour:
- Reset (async assert, sync release): state=IDLE; wr_ptr=0, rd_ptr=0, o_en_d=0. All outputs 0: out_valid, out_last, count, checksum, done, overflow. Buffer contents are don't-care.
- Edge detect: o_en_d registers o_en every cycle. cap_evt = o_en && !o_en_d. A level held high for many cycles yields exactly one capture. result is sampled in the cap_evt cycle.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - cap_evt is ignored. overflow is not set, because no job is armed.
  - start -> COLLECT. Clears wr_ptr, rd_ptr, count, checksum, done and overflow.
- COLLECT:
  - On cap_evt: mem[wr_ptr] <= result; wr_ptr++; count++; checksum ^= result. Updates are visible the next cycle.
  - When the capture makes count reach DEPTH, go to DRAIN in the same edge.
- DRAIN:
  - out_valid=1. out_data=mem[rd_ptr], read combinationally from the flop array.
  - out_last = (rd_ptr==DEPTH-1).
  - On out_valid && out_ready: rd_ptr++. If out_last, go to DONE.
  - out_data and out_valid must stay stable while out_ready=0.
- DONE: done=1, out_valid=0. Stays here until start.
- cap_evt in DRAIN or DONE: word dropped, overflow<=1 (sticky). count and checksum are unchanged.
- start in any state (including mid-COLLECT or mid-DRAIN): abort, clear as in IDLE, enter COLLECT next cycle.
- start and cap_evt in the same cycle: start wins and that word is not captured. overflow is not set.
- Latency: capture→count/checksum update is 1 cycle. Last capture→out_valid is 1 cycle. Drain sustains 1 word/cycle with out_ready held high.
- Widths: pointers are CNT_W-1 bits and wrap naturally. count saturates logically at DEPTH (64 fits in 7 bits). Checksum is bitwise XOR with no carry.
- Reset mid-operation: immediate return to reset values. A partial job is discarded.

Decomposition:
- Shared package rsa_pkg:
  - constants RSA_DATA_W=32, RSA_DEPTH=64
  - collector state enum {IDLE, COLLECT, DRAIN, DONE}
- One sub-module: rsa_word_buf, a DEPTH x DATA_W register array with one write port and one combinational read port. No reset on the data array.
- FSM, pointers, edge detect and checksum stay in rsa_result_collector.

Test Plan:
- Full job:
  - Stimulus: reset, start, then 64 o_en pulses with result=i*3+1 (i=0..63), with out_ready=1.
  - Expect: count=64. checksum = XOR of the 64 values. out_data sequence 1,4,…,190 with out_last on 190. done=1 one cycle after the last handshake. overflow=0.
- Level-held o_en:
  - Stimulus: o_en held high for 5 cycles with result changing each cycle (0xA0..0xA4).
  - Expect: only 0xA0 captured; count increments by exactly 1.
- Backpressure:
  - Stimulus: during DRAIN, toggle out_ready 1,0,0,1.
  - Expect: out_data/out_valid unchanged during the 0 cycles. No word skipped or duplicated. Order preserved.
- Overflow:
  - Stimulus: after job complete (DONE), pulse o_en with result=0xDEADBEEF.
  - Expect: overflow=1. checksum and count unchanged. done stays 1.
- Abort:
  - Stimulus: start mid-COLLECT at count=10 coincident with a cap_evt, then 64 new words.
  - Expect: count=0 next cycle, that word not captured, overflow=0. Second job drains only the new words.
- Async reset mid-DRAIN:
  - Stimulus: assert rst_n=0 between clock edges at rd_ptr=20.
  - Expect: out_valid, done, count and checksum are 0 immediately. After release, state is IDLE and cap_evt is ignored until start.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants and the collector state type for the RSA result capture path.
package rsa_pkg;

  localparam int RSA_DATA_W = 32;
  localparam int RSA_DEPTH  = 64;
  localparam int RSA_CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } coll_state_e;

endpackage

// File: rtl/rsa_word_buf.sv
// Word buffer for one RSA job: flop array with one synchronous write port and
// one combinational read port. Contents are not reset; only pointers qualify them.
module rsa_word_buf
  import rsa_pkg::*;
#(
  parameter int DATA_W = RSA_DATA_W,
  parameter int DEPTH  = RSA_DEPTH,
  parameter int AW     = $clog2(RSA_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the captured word at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rsa_result_collector.sv
// Captures one RSA job (DEPTH words announced by rising o_en edges), tracks a
// running count and XOR checksum, then drains the words over valid/ready.
module rsa_result_collector
  import rsa_pkg::*;
#(
  parameter int DATA_W = RSA_DATA_W,
  parameter int DEPTH  = RSA_DEPTH,
  parameter int CNT_W  = RSA_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              o_en,
  input  logic [DATA_W-1:0] result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] checksum,
  output logic              done,
  output logic              overflow
);

  localparam int AW = CNT_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);

  coll_state_e       state_q;
  coll_state_e       state_d;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              o_en_d;
  logic              cap_evt;
  logic              cap_wr;
  logic              ovf_set;
  logic              rd_inc;

  // A level held high on o_en announces only one word.
  assign cap_evt = o_en && !o_en_d;

  // Status outputs decode straight from state so reset clears them at once.
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (rd_ptr == LAST_PTR);
  assign done      = (state_q == DONE);
  assign rd_inc    = (state_q == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus capture and overflow strobes; start overrides everything.
  always_comb begin
    state_d = state_q;
    cap_wr  = 1'b0;
    ovf_set = 1'b0;
    if (start) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COLLECT: begin
          if (cap_evt) begin
            cap_wr = 1'b1;
            if (count == LAST_CNT) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cap_evt) begin
            ovf_set = 1'b1;
          end
          if (out_ready && (rd_ptr == LAST_PTR)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (cap_evt) begin
            ovf_set = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Edge-detect history, pointers, count, checksum and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_en_d   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      checksum <= '0;
      overflow <= 1'b0;
    end else begin
      o_en_d <= o_en;
      if (start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        checksum <= '0;
        overflow <= 1'b0;
      end else begin
        if (cap_wr) begin
          wr_ptr   <= wr_ptr + 1'b1;
          count    <= count + 1'b1;
          checksum <= checksum ^ result;
        end
        if (rd_inc) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (ovf_set) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  rsa_word_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk   (clk),
    .we    (cap_wr),
    .waddr (wr_ptr),
    .wdata (result),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_rsa_result_collector.sv
// Randomized bench for rsa_result_collector with a queue-based job model.
module tb_rsa_result_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        o_en;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [6:0]  count;
  logic [31:0] checksum;
  logic        done;
  logic        overflow;

  int          n_chk;
  int          n_pass;
  logic [31:0] q[$];
  logic [6:0]  cnt_before;
  logic [31:0] sum_before;

  rsa_result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .o_en      (o_en),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count),
    .checksum  (checksum),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] xor_q();
    logic [31:0] x;
    x = '0;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // One o_en announcement held for 'hold' cycles; result wanders after the first.
  task automatic pulse(input logic [31:0] v, input int hold, input bit armed);
    o_en = 1'b1;
    result = v;
    if (armed) q.push_back(v);
    for (int h = 0; h < hold; h++) begin
      sync();
      result = $urandom;
    end
    o_en = 1'b0;
    sync();
  endtask

  task automatic do_start();
    start = 1'b1;
    sync();
    start = 1'b0;
    q.delete();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      pulse($urandom, $urandom_range(1, 3), 1'b1);
      repeat ($urandom_range(0, 2)) sync();
    end
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic drain(input int mode, input int stop_at);
    int k;
    int cyc;
    int pat[4];
    pat = '{1, 0, 0, 1};
    k = 0;
    cyc = 0;
    while (k < stop_at && cyc < 2000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4][0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, q[k]);
      chk("drain_last", out_last, (k == 63));
      chk("drain_count", count, 64);
      sync();
      if (out_ready) k++;
      cyc++;
    end
    if (k < stop_at) chk("drain_timeout", k, stop_at);
    out_ready = 1'b0;
    if (stop_at == 64) begin
      @(negedge clk);
      chk("done_after_last", done, 1);
      chk("valid_after_last", out_valid, 0);
      sync();
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    start = 1'b0;
    o_en = 1'b0;
    result = '0;
    out_ready = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_count", count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    sync();
    rst_n = 1'b1;
    sync();

    // idle ignores captures
    pulse(32'h1234_5678, 1, 1'b0);
    @(negedge clk);
    chk("idle_count", count, 0);
    chk("idle_overflow", overflow, 0);
    sync();

    // full directed job: i*3+1
    do_start();
    for (int i = 0; i < 63; i++) pulse(32'(i * 3 + 1), 1, 1'b1);
    o_en = 1'b1;
    result = 32'd190;
    q.push_back(32'd190);
    @(posedge clk);
    @(negedge clk);
    chk("last_cap_valid", out_valid, 1);
    chk("full_count", count, 64);
    chk("full_checksum", checksum, xor_q());
    chk("full_overflow", overflow, 0);
    o_en = 1'b0;
    sync();
    drain(0, 64);
    chk("full_ovf_end", overflow, 0);

    // overflow after job complete
    pulse(32'hDEAD_BEEF, 1, 1'b0);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 64);
    chk("ovf_checksum", checksum, xor_q());
    chk("ovf_done", done, 1);
    sync();

    // random job with level-held o_en and backpressure
    do_start();
    @(negedge clk);
    chk("restart_ovf", overflow, 0);
    chk("restart_count", count, 0);
    chk("restart_done", done, 0);
    sync();
    fill(5);
    @(negedge clk);
    cnt_before = count;
    sync();
    o_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      result = 32'hA0 + 32'(j);
      sync();
    end
    o_en = 1'b0;
    q.push_back(32'hA0);
    sync();
    @(negedge clk);
    chk("level_count", count, cnt_before + 7'd1);
    chk("level_checksum", checksum, xor_q());
    sync();
    fill(58);
    @(negedge clk);
    chk("job2_count", count, 64);
    chk("job2_checksum", checksum, xor_q());
    sync();
    drain(1, 64);

    // abort mid-collect with a coincident capture
    do_start();
    fill(10);
    @(negedge clk);
    chk("pre_abort_count", count, 10);
    sync();
    start = 1'b1;
    o_en = 1'b1;
    result = 32'h55AA_55AA;
    sync();
    start = 1'b0;
    o_en = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_count", count, 0);
    chk("abort_checksum", checksum, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_valid", out_valid, 0);
    sync();
    fill(64);
    @(negedge clk);
    chk("job3_checksum", checksum, xor_q());
    chk("job3_overflow", overflow, 0);
    sync();
    drain(2, 64);

    // async reset mid-drain
    do_start();
    fill(64);
    drain(0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_count", count, 0);
    chk("arst_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    pulse(32'hCAFE_F00D, 1, 1'b0);
    @(negedge clk);
    chk("post_rst_count", count, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_overflow", overflow, 0);
    sync();
    do_start();
    fill(3);
    @(negedge clk);
    chk("post_rst_job_count", count, 3);
    chk("post_rst_job_sum", checksum, xor_q());
    sync();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
